// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// Produces {remainder, quotient} after 32 iterations plus one sign-correction edge.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_div,
    input  logic        annul,
    input  logic [31:0] opdata1,
    input  logic [31:0] opdata2,
    output logic [63:0] result,
    output logic        ready,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StDivZero, StOn, StEnd} state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [64:0] part_q, part_d;
    logic [31:0] dsor_q, dsor_d;
    logic        quo_neg_q, quo_neg_d;
    logic        rem_neg_q, rem_neg_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;

    logic [31:0] dvd_mag, dsor_mag;
    logic [33:0] trial;
    logic [31:0] quo_fix, rem_fix;

    // Operand magnitudes; only signed operations take the two's complement.
    always_comb begin
        dvd_mag  = (signed_div && opdata1[31]) ? (~opdata1 + 32'd1) : opdata1;
        dsor_mag = (signed_div && opdata2[31]) ? (~opdata2 + 32'd1) : opdata2;
    end

    // Trial subtract on the remainder field plus the next dividend bit ([64:32]); the
    // extra MSB keeps the shifted remainder exact when the divisor exceeds 2^31.
    always_comb begin
        trial   = {1'b0, part_q[64:32]} - {2'b00, dsor_q};
        quo_fix = quo_neg_q ? (~part_q[31:0] + 32'd1) : part_q[31:0];
        rem_fix = rem_neg_q ? (~part_q[64:33] + 32'd1) : part_q[64:33];
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        part_d    = part_q;
        dsor_d    = dsor_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        result_d  = result_q;
        ready_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && !annul) begin
                    dsor_d    = dsor_mag;
                    quo_neg_d = signed_div & (opdata1[31] ^ opdata2[31]);
                    rem_neg_d = signed_div & opdata1[31];
                    if (opdata2 == 32'd0) begin
                        state_d = StDivZero;
                    end else begin
                        state_d = StOn;
                        cnt_d   = 6'd0;
                        part_d  = {32'd0, dvd_mag, 1'b0};
                    end
                end
            end
            StDivZero: begin
                if (annul) begin
                    state_d = StIdle;
                end else begin
                    result_d = 64'd0;
                    ready_d  = 1'b1;
                    state_d  = StEnd;
                end
            end
            StOn: begin
                if (annul) begin
                    state_d = StIdle;
                end else if (cnt_q != 6'd32) begin
                    if (!trial[33]) begin
                        part_d = {trial[31:0], part_q[31:0], 1'b1};
                    end else begin
                        part_d = {part_q[63:0], 1'b0};
                    end
                    cnt_d = cnt_q + 6'd1;
                end else begin
                    result_d = {rem_fix, quo_fix};
                    ready_d  = 1'b1;
                    state_d  = StEnd;
                end
            end
            StEnd: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= 6'd0;
            part_q    <= 65'd0;
            dsor_q    <= 32'd0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            result_q  <= 64'd0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            part_q    <= part_d;
            dsor_q    <= dsor_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign result = result_q;
    assign ready  = ready_q;
    assign busy   = (state_q != StIdle);

endmodule
